// File: rtl/decoder_seq.sv
// -----------------------------------------------------------------------------
// decoder_seq
//
// Parametrised N-to-2^N one-hot decoder with registered outputs and a built-in
// scan sequencer. The block is meant to drive the one-hot select lines of
// LED, 7-segment or keypad banks.
//
// In direct mode the address input is decoded onto the select bus. In scan
// mode an internal address counter starts at addr and walks the outputs up or
// down. Each output is held for dwell+1 cycles.
//
// Parameters
//   N        address width, legal range 1..6; the select bus is 2^N bits
//   DWELL_W  width of the dwell input
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   en     in   block enable; low forces every select output to zero
//   mode   in   0 = direct decode, 1 = scan
//   addr   in   direct-mode address; also the scan start address
//   dir    in   scan direction: 0 = up, 1 = down
//   dwell  in   clock cycles per scan step, minus 1
//   d      out  registered one-hot select; d[i] high selects output i
//   cur    out  registered address currently driven onto d
//   wrap   out  one-cycle pulse on the edge where the scan address wraps
// -----------------------------------------------------------------------------
module decoder_seq #(
  parameter int unsigned N       = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         addr,
  input  logic                 dir,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(1<<N)-1:0]    d,
  output logic [N-1:0]         cur,
  output logic                 wrap
);

  localparam int unsigned W = 1 << N;

  localparam logic [N-1:0]       ADDR_ONE = N'(1);
  localparam logic [N-1:0]       ADDR_MAX = {N{1'b1}};
  localparam logic [N-1:0]       ADDR_MIN = '0;
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;

  // Exactly one bit set. A multi-hot value can never reach d.
  function automatic logic [W-1:0] one_hot(input logic [N-1:0] a);
    logic [W-1:0] r;
    // NOTE: give r a full default before the indexed write so that every bit
    // has a defined value on every call.
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

  // Next scan address, modulo 2^N. N-bit arithmetic wraps on its own.
  function automatic logic [N-1:0] step_addr(input logic [N-1:0] a,
                                             input logic         down);
    return down ? (a - ADDR_ONE) : (a + ADDR_ONE);
  endfunction

  // A step wraps when it crosses the 0 / 2^N-1 boundary in either direction.
  function automatic logic step_wraps(input logic [N-1:0] a,
                                      input logic         down);
    return down ? (a == ADDR_MIN) : (a == ADDR_MAX);
  endfunction

  // The state register and all outputs sit in one clocked process. Because
  // the outputs are registered, no input has a combinational path to d, cur
  // or wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments, so every branch reads the
      // values from before the edge, whatever order the branches are written.
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
      d     <= '0;
      wrap  <= 1'b0;
    end else if (!en) begin
      // Idle blanks the bus. cur keeps its last value for observation only;
      // the next scan entry reloads it from addr.
      state <= IDLE;
      cnt   <= '0;
      d     <= '0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state <= DIRECT;
      cnt   <= '0;
      cur   <= addr;
      d     <= one_hot(addr);
      wrap  <= 1'b0;
    end else if (state != SCAN) begin
      // Scan entry loads the start address. No step happens on this edge.
      state <= SCAN;
      cnt   <= '0;
      cur   <= addr;
      d     <= one_hot(addr);
      wrap  <= 1'b0;
    end else if (cnt >= dwell) begin
      // Use >= rather than ==. If dwell drops below a count already reached,
      // the step happens on the next edge and does not wait for the counter
      // to roll over.
      cnt   <= '0;
      cur   <= step_addr(cur, dir);
      d     <= one_hot(step_addr(cur, dir));
      wrap  <= step_wraps(cur, dir);
    end else begin
      cnt   <= cnt + CNT_ONE;
      wrap  <= 1'b0;
    end
  end

endmodule
